// File: rtl/colparity_pkg.sv
// rtl/colparity_pkg.sv - shared state encoding and default parameters for the colParity batch sequencer
package colparity_pkg;

    localparam int IDX_W_DEF        = 10;
    localparam int START_CYCLES_DEF = 3;
    localparam int TIMEOUT_DEF      = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/colparity_cycle_cnt.sv
// rtl/colparity_cycle_cnt.sv - loadable/clearable down-counter that stops at zero
module colparity_cycle_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clr,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/colparity_batch_ctrl.sv
// rtl/colparity_batch_ctrl.sv - runs the colParity core over a range of file indices
// Optional WAIT timeout enabled by defining COLPARITY_TIMEOUT_EN.
module colparity_batch_ctrl
    import colparity_pkg::*;
#(
    parameter int IDX_W        = IDX_W_DEF,
    parameter int START_CYCLES = START_CYCLES_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [IDX_W-1:0] first_index,
    input  logic [IDX_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] jobs_done,
    output logic             core_start,
    output logic [IDX_W-1:0] core_file_index,
    input  logic             core_finish
);

    localparam int SC_W = $clog2(START_CYCLES + 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] jobs_q, jobs_d;
    logic             st_zero;
    logic             st_load;
`ifdef COLPARITY_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic             err_q, err_d;
    logic             to_zero;
    logic             to_load;
`endif

    // Counter is preloaded with N-1 so it reads zero on the N-th START cycle.
    assign st_load = (state_d == START) && (state_q != START);

    colparity_cycle_cnt #(.W(SC_W)) u_start_cnt (
        .clk      (clk),
        .rst_n    (rst),
        .load     (st_load),
        .clr      (1'b0),
        .dec      (state_q == START),
        .load_val (SC_W'(START_CYCLES - 1)),
        .zero     (st_zero)
    );

`ifdef COLPARITY_TIMEOUT_EN
    assign to_load = (state_d == WAIT) && (state_q != WAIT);

    colparity_cycle_cnt #(.W(TO_W)) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst),
        .load     (to_load),
        .clr      (1'b0),
        .dec      (state_q == WAIT),
        .load_val (TO_W'(TIMEOUT - 1)),
        .zero     (to_zero)
    );
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        jobs_d  = jobs_q;
`ifdef COLPARITY_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    jobs_d = '0;
`ifdef COLPARITY_TIMEOUT_EN
                    err_d  = 1'b0;
`endif
                    if (count != '0) begin
                        idx_d   = first_index;
                        cnt_d   = count;
                        state_d = START;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            START: begin
                if (st_zero) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A finish arriving on the expiry edge wins over the timeout.
                if (core_finish) begin
                    jobs_d = jobs_q + IDX_W'(1);
                    if (jobs_d == cnt_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = START;
                    end
                end
`ifdef COLPARITY_TIMEOUT_EN
                else if (to_zero) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            jobs_q  <= '0;
`ifdef COLPARITY_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            jobs_q  <= jobs_d;
`ifdef COLPARITY_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    // Outputs decode straight from state so reset clears them without a clock edge.
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign core_start      = (state_q == START);
    assign jobs_done       = jobs_q;
    assign core_file_index = idx_q;
`ifdef COLPARITY_TIMEOUT_EN
    assign err             = err_q;
`else
    assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_colparity_batch_ctrl.sv
// tb/tb_colparity_batch_ctrl.sv - randomized self-checking bench for colparity_batch_ctrl
module tb_colparity_batch_ctrl;

    localparam int IW = 10;
    localparam int SC = 3;
    localparam int TO = 16;
`ifdef COLPARITY_TIMEOUT_EN
    localparam int W_FIRST = 12;
`else
    localparam int W_FIRST = 20;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic [IW-1:0] first_index = '0;
    logic [IW-1:0] count = '0;
    logic          busy, done, err, core_start;
    logic [IW-1:0] jobs_done, core_file_index;
    logic          core_finish = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    colparity_batch_ctrl #(
        .IDX_W        (IW),
        .START_CYCLES (SC),
        .TIMEOUT      (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .first_index     (first_index),
        .count           (count),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .jobs_done       (jobs_done),
        .core_start      (core_start),
        .core_file_index (core_file_index),
        .core_finish     (core_finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".err"}, 32'(err), 0);
        chk({tag, ".jobs"}, 32'(jobs_done), 0);
        chk({tag, ".start"}, 32'(core_start), 0);
        chk({tag, ".idx"}, 32'(core_file_index), 0);
    endtask

    // The reference is simply: job k uses index (first+k) mod 2^IW, SC start cycles,
    // then W wait cycles with finish on the W-th; done follows the last job.
    task automatic run_batch(input int first, input int cnt, input int wmin, input int wmax,
                             input bit noise, input int rst_job, input int hang_job);
        int exp_idx;
        int w_len;
        @(negedge clk);
        req = 1'b1;
        first_index = first[IW-1:0];
        count = cnt[IW-1:0];
        if (cnt == 0) begin
            @(negedge clk);
            req = 1'b0;
            chk("zero.done", 32'(done), 1);
            chk("zero.busy", 32'(busy), 1);
            chk("zero.start", 32'(core_start), 0);
            chk("zero.jobs", 32'(jobs_done), 0);
            chk("zero.err", 32'(err), 0);
            @(negedge clk);
            chk("zero.idle_busy", 32'(busy), 0);
            chk("zero.idle_done", 32'(done), 0);
            return;
        end
        for (int k = 0; k < cnt; k++) begin
            exp_idx = (first + k) % (1 << IW);
            for (int s = 0; s < SC; s++) begin
                @(negedge clk);
                chk("start.core_start", 32'(core_start), 1);
                chk("start.idx", 32'(core_file_index), 32'(exp_idx));
                chk("start.busy", 32'(busy), 1);
                chk("start.done", 32'(done), 0);
                chk("start.jobs", 32'(jobs_done), 32'(k));
                chk("start.err", 32'(err), 0);
                req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                if (k == 0 && s == 0) begin
                    first_index = IW'($urandom);
                    count = IW'($urandom);
                end
                if (noise) core_finish = 1'($urandom_range(0, 1));
            end
            w_len = (k == hang_job) ? TO : $urandom_range(wmin, wmax);
            for (int w = 1; w <= w_len; w++) begin
                @(negedge clk);
                chk("wait.core_start", 32'(core_start), 0);
                chk("wait.idx", 32'(core_file_index), 32'(exp_idx));
                chk("wait.busy", 32'(busy), 1);
                chk("wait.jobs", 32'(jobs_done), 32'(k));
                req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                if (k == rst_job && w == 2) begin
                    #1;
                    rst = 1'b0;
                    req = 1'b0;
                    core_finish = 1'b0;
                    #1;
                    chk_all_zero("midrst");
                    @(negedge clk);
                    rst = 1'b1;
                    return;
                end
                core_finish = (k != hang_job) && (w == w_len);
            end
            if (k == hang_job) begin
                @(negedge clk);
                req = 1'b0;
                chk("hang.done", 32'(done), 1);
                chk("hang.err", 32'(err), 1);
                chk("hang.jobs", 32'(jobs_done), 32'(k));
                @(negedge clk);
                chk("hang.busy_drop", 32'(busy), 0);
                chk("hang.err_sticky", 32'(err), 1);
                return;
            end
        end
        @(negedge clk);
        req = 1'b0;
        core_finish = 1'b0;
        chk("end.done", 32'(done), 1);
        chk("end.jobs", 32'(jobs_done), 32'(cnt));
        chk("end.busy", 32'(busy), 1);
        chk("end.start", 32'(core_start), 0);
        chk("end.err", 32'(err), 0);
        @(negedge clk);
        chk("end.busy_drop", 32'(busy), 0);
        chk("end.done_drop", 32'(done), 0);
        chk("end.jobs_hold", 32'(jobs_done), 32'(cnt));
    endtask

    initial begin
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        run_batch(0, 3, W_FIRST, W_FIRST, 1'b0, -1, -1);
        run_batch(5, 0, 1, 1, 1'b0, -1, -1);
        run_batch(1022, 4, 1, 6, 1'b0, -1, -1);
        run_batch(0, 3, 2, 6, 1'b1, -1, -1);
        run_batch(0, 3, 3, 6, 1'b0, 1, -1);
        run_batch(5, 1, 1, 4, 1'b0, -1, -1);
`ifdef COLPARITY_TIMEOUT_EN
        run_batch(100, 3, 1, 6, 1'b0, -1, 1);
        run_batch(7, 2, 1, 6, 1'b0, -1, -1);
`endif
        for (int i = 0; i < 20; i++) begin
            run_batch((i % 4 == 0) ? $urandom_range(1018, 1023) : $urandom_range(0, 1023),
                      $urandom_range(0, 5), 1, 8, 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/colparity_batch_ctrl.md
# colparity_batch_ctrl

Sequencer that runs the `colParity` core over a contiguous range of file indices without testbench or host involvement. It accepts one batch request (first index, count) and then, per file, drives the core's `file_index` and `start`. It waits for the core's `finish`, advances the index, and reports completion and progress. It sits directly in front of one `colParity` instance, and its `core_*` ports wire one-to-one to that core.

## Interface
Parameters:
- `IDX_W`, default 10: width of file index and count; matches the core's `file_index`.
- `START_CYCLES`, default 3: number of cycles `core_start` is held high per job (≥1).
- `TIMEOUT`, default 4096: maximum number of WAIT cycles per job; used only when `COLPARITY_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  system clock; rising-edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `req`  in  1  batch request; sampled only in IDLE.
- `first_index`  in  IDX_W  first file index; captured with `req`.
- `count`  in  IDX_W  number of files in the batch; captured with `req`.
- `busy`  out  1  high from the cycle after acceptance until DONE, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  timeout flag; sticky until the next accepted `req`.
- `jobs_done`  out  IDX_W  number of files finished in the current or last batch.
- `core_start`  out  1  to core `start`.
- `core_file_index`  out  IDX_W  to core `file_index`; stable for the whole job.
- `core_finish`  in  1  from core `finish` (level).

## Operation
- FSM states: IDLE, START, WAIT, DONE.
- IDLE, with `req`=1 and `count`≠0: capture `first_index` and `count`, clear `jobs_done` and `err`, go to START.
- IDLE, with `req`=1 and `count`=0: clear `jobs_done` and `err`, go to DONE. No `core_start` is issued.
- START: `core_start`=1 for exactly START_CYCLES cycles, then go to WAIT.
- WAIT: `core_start`=0. `core_finish` is sampled only in this state.
  - On `core_finish`=1, increment `jobs_done`.
  - If the new value equals the captured count, go to DONE.
  - Otherwise increment `core_file_index` and go to START.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `core_file_index` increments modulo 2^IDX_W, so the range wraps: first=1022, count=4 produces 1022, 1023, 0, 1.
- `req` in any state other than IDLE is ignored. It is not queued.
- `core_finish` in IDLE, START or DONE is ignored. This covers the stale level left over from the previous job.
- Captured `first_index` and `count` are immune to input changes after acceptance.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `jobs_done`=0, `core_start`=0, `core_file_index`=0; state is IDLE.
- Reset mid-batch forces these values immediately and asynchronously, without waiting for a clock edge. `core_start` drops in the same instant.
- `req` sampled at edge T: `busy`=1 and `core_start`=1 from T+1.
- Per job: START_CYCLES cycles of START, then W WAIT cycles, where `core_finish` is seen at the W-th sampling edge (W≥1).
- The next job's `core_start` rises on the cycle after that W-th edge.
- For the last job, `done` and the final `jobs_done` value appear on the cycle after that W-th edge. `busy` drops the following cycle.
- Back-to-back batches: a new `req` can be accepted in the first IDLE cycle after DONE.

## Configuration
- Macro: `COLPARITY_TIMEOUT_EN`.
- Defined:
  - A WAIT-cycle counter clears on entry to WAIT.
  - If TIMEOUT cycles elapse without `core_finish`, `err`=1 and the FSM goes to DONE (`done` still pulses).
  - `jobs_done` holds the number of completed files.
  - `core_finish` on the same edge as expiry counts as success.
- Not defined: no counter is synthesised, WAIT waits indefinitely, and `err` is tied to 0.

## Structure
- Package `colparity_pkg` holds:
  - the FSM state enum (`IDLE`, `START`, `WAIT`, `DONE`);
  - default localparams for IDX_W, START_CYCLES and TIMEOUT, shared with the `colParity` wrapper and bench.
- One sub-module, `colparity_cycle_cnt`: a loadable/clearable down-counter with an async active-low reset.
  - Instantiated for the START hold.
  - Instantiated a second time, under the macro, for the timeout.
- Everything else is in the top module.

## Test plan
- Reset, then first=0, count=3, core finishing 20 cycles after `start` falls:
  - `core_file_index` is 0, 1, 2, each with 3 `core_start` cycles;
  - `jobs_done` ends at 3, one `done` pulse, `err`=0.
- count=0: `done` on the cycle after `req`; `core_start` never rises; `jobs_done`=0.
- first=1022, count=4: indices 1022, 1023, 0, 1; `jobs_done`=4.
- `req` pulsed while busy, and `core_finish` held high during START: neither affects sequencing; indices and counts match the single-batch case.
- `rst`=0 asserted mid-WAIT of job 2:
  - all outputs are 0 immediately;
  - after release, a new batch (first=5, count=1) runs cleanly.
- With `COLPARITY_TIMEOUT_EN` defined and TIMEOUT=16, and the core never finishing job 2 of 3:
  - `err`=1, `done` pulses, `jobs_done`=1;
  - the next `req` clears `err`.
